psu_tach_monitor: RTL and testbench

- Upstream stage of the LED block. Measures the PSU1 fan tach pulse rate over a window timed by Strobe16ms.
- Debounces out-of-range windows into the PSU1_Tach_Low and PSU1_Tach_High flags that PSU LED logic consumes. Output pair 2'b00 means healthy.
- Clocked by SlowClock (32,768 Hz). Sits beside the fan/LAN LED logic in the display hierarchy.

---
 rtl/psu_mon_pkg.sv | 27 ++
 rtl/psu_tach_monitor_tach_edge_sync.sv | 69 ++++++
 rtl/psu_tach_monitor.sv | 140 ++++++++++++++
 tb/tb_psu_tach_monitor.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/psu_mon_pkg.sv
// Shared types and default constants for the PSU tach monitor.
package psu_mon_pkg;

  localparam int unsigned CNT_W_DEF          = 8;
  localparam int unsigned WINDOW_STROBES_DEF = 64;
  localparam int unsigned LOW_LIMIT_DEF      = 20;
  localparam int unsigned HIGH_LIMIT_DEF     = 200;
  localparam int unsigned FAULT_WINDOWS_DEF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MONITOR = 2'd2
  } mon_state_e;

  // Flag pair as {Low, High}
  typedef enum logic [1:0] {
    FLAG_OK   = 2'b00,
    FLAG_HIGH = 2'b01,
    FLAG_LOW  = 2'b10
  } tach_flag_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/psu_tach_monitor_tach_edge_sync.sv
// Tach synchronizer and registered rising-edge detect.
// TACH_GLITCH_FILTER_EN inserts a 3-sample majority filter (edge latency 3 -> 5 cycles).
module tach_edge_sync
  import psu_mon_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic tach_raw,
  output logic tach_edge
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic edge_q, edge_d;
  logic det_in;

`ifdef TACH_GLITCH_FILTER_EN
  logic hist0_q, hist0_d;
  logic hist1_q, hist1_d;
  logic filt_q, filt_d;

  always_comb begin
    hist0_d = sync2_q;
    hist1_d = hist0_q;
    filt_d  = maj3(sync2_q, hist0_q, hist1_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist0_q <= 1'b0;
      hist1_q <= 1'b0;
      filt_q  <= 1'b0;
    end else begin
      hist0_q <= hist0_d;
      hist1_q <= hist1_d;
      filt_q  <= filt_d;
    end
  end

  assign det_in = filt_q;
`else
  assign det_in = sync2_q;
`endif

  always_comb begin
    sync1_d = tach_raw;
    sync2_d = sync1_q;
    prev_d  = det_in;
    edge_d  = det_in & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      edge_q  <= edge_d;
    end
  end

  assign tach_edge = edge_q;

endmodule

// File: rtl/psu_tach_monitor.sv
// PSU1 fan tach rate monitor: windowed pulse count plus debounced low/high flags.
// Optional glitch filter in the input path: TACH_GLITCH_FILTER_EN.
module psu_tach_monitor
  import psu_mon_pkg::*;
#(
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned WINDOW_STROBES = WINDOW_STROBES_DEF,
  parameter int unsigned LOW_LIMIT      = LOW_LIMIT_DEF,
  parameter int unsigned HIGH_LIMIT     = HIGH_LIMIT_DEF,
  parameter int unsigned FAULT_WINDOWS  = FAULT_WINDOWS_DEF
) (
  input  logic             SlowClock,
  input  logic             Reset_N,
  input  logic             Strobe16ms,
  input  logic             Enable,
  input  logic             PSU1_Tach,
  output logic             PSU1_Tach_Low,
  output logic             PSU1_Tach_High,
  output logic [CNT_W-1:0] TachCount,
  output logic             CountValid
);

  localparam int unsigned WIN_W = $clog2(WINDOW_STROBES + 1);
  localparam int unsigned RUN_W = $clog2(FAULT_WINDOWS + 1);

  mon_state_e       state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] pulse_q, pulse_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  tach_flag_e       flag_q, flag_d;
  logic [RUN_W-1:0] low_run_q, low_run_d;
  logic [RUN_W-1:0] high_run_q, high_run_d;
  logic [RUN_W-1:0] good_run_q, good_run_d;

  logic tach_edge;
  logic win_close_c;
  logic is_low_c;
  logic is_high_c;

  tach_edge_sync u_edge (
    .clk      (SlowClock),
    .rst_n    (Reset_N),
    .tach_raw (PSU1_Tach),
    .tach_edge(tach_edge)
  );

  assign win_close_c = Strobe16ms && (win_q == WIN_W'(WINDOW_STROBES - 1));
  assign is_low_c    = 32'(pulse_q) < LOW_LIMIT;
  assign is_high_c   = 32'(pulse_q) > HIGH_LIMIT;

  always_ff @(posedge SlowClock) begin
    if (!Reset_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!Enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_SETTLE;
        ST_SETTLE:  if (win_close_c) state_d = ST_MONITOR;
        ST_MONITOR: state_d = ST_MONITOR;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Window counting, count latch and run-length debounce
  always_comb begin
    win_d      = win_q;
    pulse_d    = pulse_q;
    count_d    = count_q;
    valid_d    = 1'b0;
    flag_d     = flag_q;
    low_run_d  = low_run_q;
    high_run_d = high_run_q;
    good_run_d = good_run_q;
    if (!Enable || state_q == ST_IDLE) begin
      win_d      = '0;
      pulse_d    = '0;
      flag_d     = FLAG_OK;
      low_run_d  = '0;
      high_run_d = '0;
      good_run_d = '0;
    end else if (win_close_c) begin
      win_d   = '0;
      pulse_d = CNT_W'(tach_edge);
      if (state_q == ST_MONITOR) begin
        count_d = pulse_q;
        valid_d = 1'b1;
        low_run_d  = '0;
        high_run_d = '0;
        good_run_d = '0;
        if (is_low_c)
          low_run_d = (low_run_q == RUN_W'(FAULT_WINDOWS)) ? low_run_q : low_run_q + RUN_W'(1);
        else if (is_high_c)
          high_run_d = (high_run_q == RUN_W'(FAULT_WINDOWS)) ? high_run_q : high_run_q + RUN_W'(1);
        else
          good_run_d = (good_run_q == RUN_W'(FAULT_WINDOWS)) ? good_run_q : good_run_q + RUN_W'(1);
        if (low_run_d == RUN_W'(FAULT_WINDOWS))       flag_d = FLAG_LOW;
        else if (high_run_d == RUN_W'(FAULT_WINDOWS)) flag_d = FLAG_HIGH;
        else if (good_run_d == RUN_W'(FAULT_WINDOWS)) flag_d = FLAG_OK;
      end
    end else begin
      if (Strobe16ms) win_d = win_q + WIN_W'(1);
      if (tach_edge && pulse_q != '1) pulse_d = pulse_q + CNT_W'(1);
    end
  end

  always_ff @(posedge SlowClock) begin
    if (!Reset_N) begin
      win_q      <= '0;
      pulse_q    <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      flag_q     <= FLAG_OK;
      low_run_q  <= '0;
      high_run_q <= '0;
      good_run_q <= '0;
    end else begin
      win_q      <= win_d;
      pulse_q    <= pulse_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      flag_q     <= flag_d;
      low_run_q  <= low_run_d;
      high_run_q <= high_run_d;
      good_run_q <= good_run_d;
    end
  end

  assign PSU1_Tach_Low  = flag_q[1];
  assign PSU1_Tach_High = flag_q[0];
  assign TachCount      = count_q;
  assign CountValid     = valid_q;

endmodule

// File: tb/tb_psu_tach_monitor.sv
// Randomized scoreboard bench for psu_tach_monitor with a window-level reference model.
`timescale 1ns/1ps
module tb_psu_tach_monitor;

  localparam int WIN_CYC  = 1280;
  localparam int STRB_GAP = 20;
  localparam int NSTRB    = 64;
`ifdef TACH_GLITCH_FILTER_EN
  localparam int LAT  = 5;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = 3;
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, strobe, en, tach;
  logic       low_o, high_o, valid_o;
  logic [7:0] count_o;

  psu_tach_monitor dut (
    .SlowClock     (clk),
    .Reset_N       (rst_n),
    .Strobe16ms    (strobe),
    .Enable        (en),
    .PSU1_Tach     (tach),
    .PSU1_Tach_Low (low_o),
    .PSU1_Tach_High(high_o),
    .TachCount     (count_o),
    .CountValid    (valid_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] cnt;
    logic       lo;
    logic       hi;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_n = 0;

  // Reference model state: counted-edge times, window bookkeeping, flag history
  int   cnt_edges[$];
  int   cls_hist[$];
  int   win_start = 0;
  int   strb_n = 0;
  int   win_idx = 0;
  bit   act = 1'b0;
  bit   prev_tach = 1'b0;
  bit   m_lo = 1'b0;
  bit   m_hi = 1'b0;
  int   m_last = 0;
  bit   pat [WIN_CYC];

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // A closed window counts edges registered in [win_start, c); the closing edge goes to the next window
  task automatic close_win(input int c);
    int n = 0;
    int cls;
    while (cnt_edges.size() > 0 && cnt_edges[0] < c) begin
      if (cnt_edges[0] >= win_start) n++;
      void'(cnt_edges.pop_front());
    end
    if (n > 255) n = 255;
    win_start = c;
    strb_n = 0;
    if (win_idx > 0) begin
      cls = (n < 20) ? 1 : (n > 200) ? 2 : 0;
      cls_hist.push_back(cls);
      if (cls_hist.size() > 3) void'(cls_hist.pop_front());
      if (cls_hist.size() == 3 && cls_hist[0] == cls && cls_hist[1] == cls) begin
        m_lo = (cls == 1);
        m_hi = (cls == 2);
      end
      m_last = n;
      exp_q.push_back({8'(n), m_lo, m_hi});
    end
    win_idx++;
  endtask

  task automatic drive(input bit r, input bit e, input bit s, input bit t, input bit nxt_t);
    int de;
    @(negedge clk);
    de = edge_n + 1;
    rst_n = r; en = e; strobe = s; tach = t;
    if (!r) m_last = 0;
    if (!(r && e)) begin
      act = 1'b0; strb_n = 0; m_lo = 1'b0; m_hi = 1'b0;
    end else if (!act) begin
      act = 1'b1; win_start = de + 1; strb_n = 0; win_idx = 0;
      cls_hist.delete(); m_lo = 1'b0; m_hi = 1'b0;
    end
    if (r && t && !prev_tach && !(FILT && !nxt_t)) cnt_edges.push_back(de + LAT);
    prev_tach = t;
    if (act && s && de >= win_start) begin
      if (strb_n == NSTRB - 1) close_win(de);
      else strb_n++;
    end
  endtask

  // mode 0: 2-cycle pulses, 1: 1-cycle glitches, 2: last pulse lands on the closing strobe
  task automatic run_window(input int n, input int mode, input int ncyc);
    int np, slack, pos, ex;
    for (int t = 0; t < WIN_CYC; t++) pat[t] = 1'b0;
    np = (mode == 2) ? n - 1 : n;
    slack = WIN_CYC - 4 * np - 16;
    pos = 4;
    for (int i = 0; i < np; i++) begin
      ex = int'($urandom_range(0, slack / (np - i)));
      slack -= ex;
      pos += ex;
      pat[pos] = 1'b1;
      if (mode != 1) pat[pos + 1] = 1'b1;
      pos += 4;
    end
    if (mode == 2) begin
      pat[WIN_CYC - 1 - LAT] = 1'b1;
      pat[WIN_CYC - LAT]     = 1'b1;
    end
    for (int t = 0; t < ncyc; t++)
      drive(1'b1, 1'b1, (t % STRB_GAP) == STRB_GAP - 1, pat[t],
            (t + 1 < WIN_CYC) ? pat[t + 1] : 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_count_valid: got 1, want 0 (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("tach_count", 32'(count_o), 32'(e.cnt));
        check("flag_low", 32'(low_o), 32'(e.lo));
        check("flag_high", 32'(high_o), 32'(e.hi));
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; strobe = 1'b0; tach = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, i == 1, (i % 2 == 0) && i < 3, 1'b0);
      if (i > 0) begin
        check("rst_low", 32'(low_o), 32'd0);
        check("rst_high", 32'(high_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
      end
    end
    repeat (5) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    run_window(100, 0, WIN_CYC);
    repeat (2) run_window(100, 0, WIN_CYC);
    repeat (3) run_window(10, 0, WIN_CYC);
    repeat (3) run_window(100, 0, WIN_CYC);
    repeat (3) run_window(300, 0, WIN_CYC);
    repeat (3) run_window(100, 0, WIN_CYC);
    for (int i = 0; i < 4; i++) run_window((i % 2) ? 300 : 10, 0, WIN_CYC);
    run_window(100, 2, WIN_CYC);
    run_window(100, 0, WIN_CYC);
    repeat (6) run_window(int'($urandom_range(1, 300)), int'($urandom_range(0, 2)), WIN_CYC);

    repeat (3) run_window(5, 0, WIN_CYC);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("low_before_disable", 32'(low_o), 32'(m_lo));
    run_window(100, 0, 300);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("disable_low", 32'(low_o), 32'd0);
    check("disable_high", 32'(high_o), 32'd0);
    check("disable_valid", 32'(valid_o), 32'd0);
    check("disable_count_hold", 32'(count_o), 32'(m_last));
    repeat (10) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_window(100, 0, WIN_CYC);
    run_window(100, 0, WIN_CYC);

    repeat (2) run_window(100, 1, WIN_CYC);
    repeat (5) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
